// File: rtl/cam_capture.sv
// OV7670 capture front-end: packs camera byte pairs into 16-bit pixels and writes
// them to a linear frame buffer. Optional per-frame geometry checking under CAP_ERR_EN.
module cam_capture #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       w_data,
    output logic              w_en,
    output logic              frame_done
`ifdef CAP_ERR_EN
    ,
    output logic              err_frame
`endif
);

    localparam int unsigned COL_W  = 10;
    localparam int unsigned LINE_W = 9;

    localparam logic [COL_W-1:0]  COL_LIM  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_LIM = LINE_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_START,
        CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic                vs_q, href_q;
    logic                phase_q, phase_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [15:0]         w_data_q, w_data_d;
    logic                w_en_q, w_en_d;
    logic                frame_done_q, frame_done_d;

    logic vs_rise, vs_fall, href_fall;

    assign vs_rise   =  cam_vsync & ~vs_q;
    assign vs_fall   = ~cam_vsync &  vs_q;
    assign href_fall = ~cam_href  &  href_q;

`ifdef CAP_ERR_EN
    logic err_q, err_d;
`endif

    // State register and all datapath flops
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_VS;
            vs_q         <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            line_base_q  <= '0;
            hi_byte_q    <= '0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CAP_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vs_q         <= cam_vsync;
            href_q       <= cam_href;
            phase_q      <= phase_d;
            col_q        <= col_d;
            line_q       <= line_d;
            line_base_q  <= line_base_d;
            hi_byte_q    <= hi_byte_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_en_q       <= w_en_d;
            frame_done_q <= frame_done_d;
`ifdef CAP_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    // Next-state and datapath; a line close is applied before a same-cycle frame close
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        line_d       = line_q;
        line_base_d  = line_base_q;
        hi_byte_d    = hi_byte_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_en_d       = 1'b0;
        frame_done_d = 1'b0;
`ifdef CAP_ERR_EN
        err_d        = err_q;
`endif

        case (state_q)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d = WAIT_START;
                end
            end

            WAIT_START: begin
                if (vs_fall) begin
                    if (capture_en) begin
                        state_d     = CAPTURE;
                        col_d       = '0;
                        line_d      = '0;
                        line_base_d = '0;
                        phase_d     = 1'b0;
`ifdef CAP_ERR_EN
                        err_d       = 1'b0;
`endif
                    end else begin
                        state_d = WAIT_VS;
                    end
                end
            end

            CAPTURE: begin
                if (cam_href) begin
                    if (!phase_q) begin
                        hi_byte_d = cam_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        col_d   = (col_q == COL_MAX) ? col_q : col_q + COL_W'(1);
                        if ((col_q < COL_LIM) && (line_q < LINE_LIM)) begin
                            w_en_d   = 1'b1;
                            w_data_d = {hi_byte_q, cam_data};
                            w_addr_d = line_base_q + ADDR_W'(col_q);
                        end
                    end
                end else if (href_fall) begin
                    phase_d = 1'b0;
                    col_d   = '0;
                    if (line_q < LINE_LIM) begin
                        line_d      = line_q + LINE_W'(1);
                        line_base_d = line_base_q + LINE_INC;
                    end
`ifdef CAP_ERR_EN
                    if ((col_q != COL_LIM) || phase_q) begin
                        err_d = 1'b1;
                    end
`endif
                end

                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_START;
`ifdef CAP_ERR_EN
                    if (line_d != LINE_LIM) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign w_en       = w_en_q;
    assign frame_done = frame_done_q;
`ifdef CAP_ERR_EN
    assign err_frame  = err_q;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 4x3 geometry (8 bytes per line).
// Exercises geometry checks on err_frame when built with CAP_ERR_EN.
module tb_cam_capture;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 17;

    logic          pclk       = 1'b0;
    logic          rst_n      = 1'b0;
    logic          cam_vsync  = 1'b0;
    logic          cam_href   = 1'b0;
    logic [7:0]    cam_data   = 8'h00;
    logic          capture_en = 1'b1;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data;
    logic          w_en;
    logic          frame_done;
`ifdef CAP_ERR_EN
    logic          err_frame;
`endif

    cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .capture_en (capture_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_en       (w_en),
        .frame_done (frame_done)
`ifdef CAP_ERR_EN
        ,
        .err_frame  (err_frame)
`endif
    );

    always #5 pclk = ~pclk;

    int   errors = 0;
    int   checks = 0;
    int   cnt    = 0;
    int   wa_q[$];
    int   wd_q[$];
    int   fd_cnt    = 0;
    logic err_at_fd = 1'b0;

    // Record every write and frame_done pulse, sampled just after the edge
    always @(posedge pclk) begin
        #1;
        if (w_en === 1'b1) begin
            wa_q.push_back(int'(w_addr));
            wd_q.push_back(int'(w_data));
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
`ifdef CAP_ERR_EN
            err_at_fd = err_frame;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge pclk);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
    endtask

    task automatic vs_high(input int n);
        repeat (n) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic vs_low(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 8'(cnt));
            cnt++;
        end
        vs_low(2);
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        fd_cnt    = 0;
        err_at_fd = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_w_en", 32'(w_en), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_w_data", 32'(w_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
`ifdef CAP_ERR_EN
        chk("rst_err", 32'(err_frame), 0);
`endif
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;

        // Nominal frame
        clear_mon();
        cnt = 0;
        vs_high(2);
        vs_low(2);
        repeat (V) send_line(8);
        vs_high(3);
        chk("nom_writes", wa_q.size(), 12);
        chk("nom_first_data", wd_q[0], 'h0001);
        for (int i = 0; i < wa_q.size(); i++) begin
            chk("nom_addr", wa_q[i], i);
            chk("nom_data", wd_q[i], ((2 * i) << 8) | (2 * i + 1));
        end
        chk("nom_fd", fd_cnt, 1);
`ifdef CAP_ERR_EN
        chk("nom_err", 32'(err_at_fd), 0);
`endif
        chk("hold_w_en", 32'(w_en), 0);
        chk("hold_w_addr", 32'(w_addr), 11);
        chk("hold_w_data", 32'(w_data), 'h1617);

        // Long line 0 (10 bytes): fifth pixel dropped, line 1 starts at H
        clear_mon();
        cnt = 0;
        vs_low(2);
        send_line(10);
        send_line(8);
        send_line(8);
        vs_high(3);
        chk("long_writes", wa_q.size(), 12);
        chk("long_l0_last_data", wd_q[3], 'h0607);
        chk("long_l1_addr", wa_q[4], 4);
        chk("long_l1_data", wd_q[4], 'h0a0b);
        chk("long_fd", fd_cnt, 1);
`ifdef CAP_ERR_EN
        chk("long_err", 32'(err_at_fd), 1);
`endif

        // Odd byte on line 1 (9 bytes): trailing byte dropped
        clear_mon();
        cnt = 0;
        vs_low(2);
        send_line(8);
        send_line(9);
        send_line(8);
        vs_high(3);
        chk("odd_writes", wa_q.size(), 12);
        chk("odd_l1_last_data", wd_q[7], 'h0e0f);
        chk("odd_l2_addr", wa_q[8], 8);
        chk("odd_l2_data", wd_q[8], 'h1112);
        chk("odd_fd", fd_cnt, 1);
`ifdef CAP_ERR_EN
        chk("odd_err", 32'(err_at_fd), 1);
`endif

        // capture_en low at frame start: frame skipped
        clear_mon();
        capture_en = 1'b0;
        cnt = 0;
        vs_low(2);
        repeat (V) send_line(8);
        vs_high(3);
        chk("skip_writes", wa_q.size(), 0);
        chk("skip_fd", fd_cnt, 0);
        capture_en = 1'b1;
        clear_mon();
        cnt = 0;
        vs_low(2);
        repeat (V) send_line(8);
        vs_high(3);
        chk("resume_writes", wa_q.size(), 12);
        chk("resume_addr0", wa_q[0], 0);
        chk("resume_data0", wd_q[0], 'h0001);
        chk("resume_fd", fd_cnt, 1);

        // Asynchronous reset in the middle of line 1
        clear_mon();
        cnt = 0;
        vs_low(2);
        send_line(8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'(cnt));
            cnt++;
        end
        #1;
        chk("pre_rst_w_en", 32'(w_en), 1);
        chk("pre_rst_w_addr", 32'(w_addr), 4);
        chk("pre_rst_w_data", 32'(w_data), 'h0809);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en", 32'(w_en), 0);
        chk("mid_rst_w_addr", 32'(w_addr), 0);
        chk("mid_rst_w_data", 32'(w_data), 0);
        chk("mid_rst_fd", 32'(frame_done), 0);
        clear_mon();
        repeat (2) drive(1'b0, 1'b1, 8'h55);
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b1, 8'h66);
        vs_low(2);
        send_line(8);
        chk("post_rst_writes", wa_q.size(), 0);
        chk("post_rst_fd", fd_cnt, 0);
        clear_mon();
        cnt = 0;
        vs_high(2);
        vs_low(2);
        repeat (V) send_line(8);
        vs_high(3);
        chk("after_rst_writes", wa_q.size(), 12);
        chk("after_rst_addr0", wa_q[0], 0);
        chk("after_rst_data0", wd_q[0], 'h0001);
        chk("after_rst_fd", fd_cnt, 1);

        // Short frame: V-1 lines
        clear_mon();
        cnt = 0;
        vs_low(2);
        send_line(8);
        send_line(8);
        vs_high(3);
        chk("short_writes", wa_q.size(), 8);
        chk("short_last_addr", wa_q[7], 7);
        chk("short_fd", fd_cnt, 1);
`ifdef CAP_ERR_EN
        chk("short_err", 32'(err_at_fd), 1);
`endif
        clear_mon();
        cnt = 0;
        vs_low(2);
        repeat (V) send_line(8);
        vs_high(3);
        chk("next_writes", wa_q.size(), 12);
        chk("next_addr0", wa_q[0], 0);
        chk("next_fd", fd_cnt, 1);
`ifdef CAP_ERR_EN
        chk("next_err", 32'(err_at_fd), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
